// File: rtl/scan_chain_seq_pkg.sv
// Shared types and defaults for the scan-chain sequencer.
// No logic; latency and backpressure are defined by the modules that import it.
package scan_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESET,
    ST_LOAD,
    ST_SHIFT,
    ST_CAPTURE,
    ST_DRAIN
  } state_t;

  localparam int CHAIN_LEN_DEF  = 16;
  localparam int CNT_W_DEF      = 5;
  localparam int NPAT_W_DEF     = 8;
  localparam int PRESET_CYC_DEF = 2;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scan_chain_seq_if.sv
// Host-side serial load/unload streams; each bit moves on valid & ready in one cycle.
// Backpressure: si_ready/so_valid may depend combinationally on the opposite stream.
interface scan_chain_seq_if;

  logic si_valid;
  logic si_data;
  logic si_ready;
  logic so_valid;
  logic so_data;
  logic so_ready;

  modport master (
    output si_valid, si_data, so_ready,
    input  si_ready, so_valid, so_data
  );

  modport slave (
    input  si_valid, si_data, so_ready,
    output si_ready, so_valid, so_data
  );

endinterface

// File: rtl/scan_chain_seq_cnt.sv
// Wrapping up-counter with terminal flag; at_term is combinational from the count register.
// inc is a plain enable (no backpressure); clr wins over inc and returns the count to zero.
module scan_seq_cnt
  import scan_seq_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic         at_term
);

  logic [W-1:0] cnt;

  assign at_term = (cnt == term);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= at_term ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/scan_chain_seq.sv
// Scan-chain sequencer: preset, serial load, one-cycle capture, overlapped unload; one bit per step cycle.
// Backpressure: any missing valid/ready on the active stream drops scan_clk_en so the chain holds.
module scan_chain_seq
  import scan_seq_pkg::*;
#(
  parameter int CHAIN_LEN  = CHAIN_LEN_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int NPAT_W     = NPAT_W_DEF,
  parameter int PRESET_CYC = PRESET_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              preset,
  input  logic [NPAT_W-1:0] npat,
  input  logic              abort,
  scan_chain_seq_if.slave   host,
  input  logic              scan_so,
  output logic              scan_se,
  output logic              scan_si,
  output logic              scan_clk_en,
  output logic              scan_setn,
  output logic              busy,
  output logic              done
);

  localparam int PRE_W = cnt_width(PRESET_CYC);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESET_CYC - 1);

  state_t            state;
  state_t            state_nxt;
  logic [NPAT_W-1:0] npat_q;
  logic              done_nxt;
  logic              bit_step;
  logic              bit_last;
  logic              pat_last;
  logic              pre_last;
  logic              cnt_clr;

  assign cnt_clr      = abort || (state == ST_IDLE);
  assign host.so_data = scan_so;

  scan_seq_cnt #(.W(CNT_W)) u_bit_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .inc     (bit_step),
    .term    (BIT_LAST),
    .at_term (bit_last)
  );

  // Only consulted in CAPTURE, which is unreachable with npat_q == 0.
  scan_seq_cnt #(.W(NPAT_W)) u_pat_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .inc     (state == ST_CAPTURE),
    .term    (npat_q - 1'b1),
    .at_term (pat_last)
  );

  scan_seq_cnt #(.W(PRE_W)) u_pre_tmr (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .inc     (state == ST_PRESET),
    .term    (PRE_LAST),
    .at_term (pre_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    done_nxt      = 1'b0;
    bit_step      = 1'b0;
    host.si_ready = 1'b0;
    host.so_valid = 1'b0;
    scan_si       = 1'b0;
    scan_clk_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (preset)          state_nxt = ST_PRESET;
          else if (npat != '0) state_nxt = ST_LOAD;
          else                 done_nxt  = 1'b1;
        end
      end
      ST_PRESET: begin
        if (pre_last) begin
          if (npat_q != '0) begin
            state_nxt = ST_LOAD;
          end else begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        host.si_ready = 1'b1;
        bit_step      = host.si_valid;
        if (bit_step) begin
          scan_clk_en = 1'b1;
          scan_si     = host.si_data;
          if (bit_last) state_nxt = ST_CAPTURE;
        end
      end
      ST_SHIFT: begin
        // Unload bit leaves on the same edge the load bit enters, so both sides must agree.
        host.si_ready = host.so_ready;
        host.so_valid = host.si_valid;
        bit_step      = host.si_valid && host.so_ready;
        if (bit_step) begin
          scan_clk_en = 1'b1;
          scan_si     = host.si_data;
          if (bit_last) state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        scan_clk_en = 1'b1;
        state_nxt   = pat_last ? ST_DRAIN : ST_SHIFT;
      end
      ST_DRAIN: begin
        host.so_valid = 1'b1;
        bit_step      = host.so_ready;
        if (bit_step) begin
          scan_clk_en = 1'b1;
          if (bit_last) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Abort freezes the chain in its current cycle and refuses both streams.
    if (abort) begin
      state_nxt     = ST_IDLE;
      done_nxt      = 1'b0;
      bit_step      = 1'b0;
      host.si_ready = 1'b0;
      host.so_valid = 1'b0;
      scan_si       = 1'b0;
      scan_clk_en   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      npat_q    <= '0;
      scan_se   <= 1'b0;
      scan_setn <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (state == ST_IDLE && start && !abort) npat_q <= npat;
      scan_se   <= (state_nxt == ST_LOAD) || (state_nxt == ST_SHIFT) || (state_nxt == ST_DRAIN);
      scan_setn <= (state_nxt != ST_PRESET);
      busy      <= (state_nxt != ST_IDLE);
      done      <= done_nxt;
    end
  end

endmodule
